// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its consumers.
package inst_fetch_pkg;

   localparam int unsigned PC_W   = 8;
   localparam int unsigned INST_W = 16;

   // Opcode field value that decode recognises as HALT.
   localparam logic [3:0] HALT_OP = 4'b1000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Prefetch FIFO: shift-down storage so the head is always entry 0 and
// vacated/flushed slots read as zero.
module fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic             head_valid,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] level;

   // Next queue contents: flush wins, otherwise pop (shift) then push at the tail.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      level   = count_q;
      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
         count_d = '0;
      end else begin
         if (pop && (count_q != '0)) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
               mem_d[i] = mem_q[i+1];
            end
            mem_d[DEPTH-1] = '0;
            level = count_q - CNT_W'(1);
         end
         if (push && (level < CNT_W'(DEPTH))) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) == level) begin
                  mem_d[i] = push_data;
               end
            end
            level = level + CNT_W'(1);
         end
         count_d = level;
      end
      valid_d = (count_d != '0);
   end

   // Queue storage, occupancy and registered head-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign head       = mem_q[0];
   assign head_valid = valid_q;
   assign count      = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC, prefetch queue, redirect flush and halt.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 8'h00,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [PC_W-1:0]   pc_out,
   input  logic [INST_W-1:0] inst_in,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_out,
   output logic [PC_W-1:0]   inst_pc,
   input  logic              inst_ready,
   output logic              halted
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             q_push, q_pop, q_flush, q_valid;
   fetch_entry_t     q_push_data, q_head;
   logic [CNT_W-1:0] q_count;

   // Next state, next PC and queue controls; redirect overrides everything.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      q_push      = 1'b0;
      q_flush     = 1'b0;
      q_pop       = q_valid & inst_ready;
      q_push_data = '{pc: pc_q, inst: inst_in};
      if (redirect) begin
         q_flush = 1'b1;
         pc_d    = redirect_pc;
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (halt) begin
            state_d = HALTED;
         end else if ((q_count < CNT_W'(DEPTH)) || q_pop) begin
            q_push = 1'b1;
            pc_d   = pc_q + PC_W'(1);
         end
      end
   end

   // FSM state and fetch address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (q_push),
      .push_data  (q_push_data),
      .pop        (q_pop),
      .flush      (q_flush),
      .head       (q_head),
      .head_valid (q_valid),
      .count      (q_count)
   );

   assign pc_out     = pc_q;
   assign inst_valid = q_valid;
   assign inst_out   = q_head.inst;
   assign inst_pc    = q_head.pc;
   assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch;

   localparam int unsigned DEPTH    = 2;
   localparam logic [7:0]  RESET_PC = 8'h00;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  pc_out;
   logic [15:0] inst_in;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic [15:0] inst_out;
   logic [7:0]  inst_pc;
   logic        inst_ready;
   logic        halted;

   logic [15:0] mem [256];

   ent_t       mq[$];
   logic [7:0] m_pc;
   bit         m_halted;

   int checks = 0;
   int errors = 0;

   inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_out      (pc_out),
      .inst_in     (inst_in),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .inst_valid  (inst_valid),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   assign inst_in = mem[pc_out];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
   endtask

   // One rising edge of the fetch unit, stated as queue operations.
   task automatic model_edge();
      if ((mq.size() != 0) && inst_ready) void'(mq.pop_front());
      if (redirect) begin
         mq.delete();
         m_pc     = redirect_pc;
         m_halted = 1'b0;
      end else if (!m_halted) begin
         if (halt) begin
            m_halted = 1'b1;
         end else if (mq.size() < DEPTH) begin
            mq.push_back('{pc: m_pc, inst: mem[m_pc]});
            m_pc = m_pc + 8'd1;
         end
      end
   endtask

   task automatic check_model();
      ent_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("pc_out",     32'(pc_out),     32'(m_pc));
      chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
      chk("inst_out",   32'(inst_out),   32'(h.inst));
      chk("inst_pc",    32'(inst_pc),    32'(h.pc));
      chk("halted",     32'(halted),     32'(m_halted));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_model();
   endtask

   // Asynchronous reset pulse between edges; outputs must settle before the next edge.
   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      chk("rst_pc_lit",    32'(pc_out),     32'(RESET_PC));
      chk("rst_valid_lit", 32'(inst_valid), 32'd0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 65535));
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; halt = 1'b0; inst_ready = 1'b0;
      model_reset();
      @(negedge clk);
      check_model();
      chk("reset_pc_lit",  32'(pc_out),     32'h00);
      chk("reset_out_lit", 32'(inst_out),   32'h0000);

      // Streaming from reset: head pc 0,1,2,... with no gaps.
      rst_n = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("stream_pc_lit",   32'(inst_pc),  32'(k));
         chk("stream_inst_lit", 32'(inst_out), 32'(mem[k]));
      end

      // Backpressure from reset: fetch stalls at pc 2, head holds pc 0.
      inst_ready = 1'b0;
      reset_pulse();
      for (int k = 0; k < 5; k++) step();
      chk("bp_pc_lit",    32'(pc_out),     32'h02);
      chk("bp_valid_lit", 32'(inst_valid), 32'd1);
      chk("bp_head_lit",  32'(inst_pc),    32'h00);
      inst_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("bp_resume_lit", 32'(inst_pc), 32'(k));
      end

      // Redirect with a full queue flushes everything.
      inst_ready = 1'b0;
      step(); step();
      chk("full_valid_lit", 32'(inst_valid), 32'd1);
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      chk("redir_valid_lit", 32'(inst_valid), 32'd0);
      chk("redir_pc_lit",    32'(pc_out),     32'h40);
      inst_ready = 1'b1;
      step();
      chk("redir_head_lit", 32'(inst_pc), 32'h40);

      // PC wrap-around after a redirect near the top of the space.
      redirect = 1'b1; redirect_pc = 8'hFE;
      step();
      redirect = 1'b0;
      step(); chk("wrap_fe_lit", 32'(inst_pc), 32'hFE);
      step(); chk("wrap_ff_lit", 32'(inst_pc), 32'hFF);
      step(); chk("wrap_00_lit", 32'(inst_pc), 32'h00);
      step(); chk("wrap_01_lit", 32'(inst_pc), 32'h01);

      // Halt at pc 5 with pc 3,4 queued; drain, then redirect back to RUN.
      inst_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h03;
      step();
      redirect = 1'b0;
      step(); step();
      chk("pre_halt_pc_lit", 32'(pc_out), 32'h05);
      halt = 1'b1;
      step();
      chk("halted_lit",      32'(halted),  32'd1);
      chk("halt_pc_lit",     32'(pc_out),  32'h05);
      chk("halt_head_lit",   32'(inst_pc), 32'h03);
      inst_ready = 1'b1;
      step(); chk("drain4_lit", 32'(inst_pc), 32'h04);
      step(); chk("drained_lit", 32'(inst_valid), 32'd0);
      step(); chk("halt_hold_lit", 32'(pc_out), 32'h05);
      chk("halt_stay_lit", 32'(halted), 32'd1);
      redirect = 1'b1; redirect_pc = 8'h00;
      step();
      redirect = 1'b0; halt = 1'b0;
      chk("resume_run_lit", 32'(halted), 32'd0);
      chk("resume_pc_lit",  32'(pc_out), 32'h00);
      step(); chk("resume_head_lit", 32'(inst_pc), 32'h00);

      // Reset pulse mid-stream restarts fetching at RESET_PC.
      step(); step();
      reset_pulse();
      step();
      chk("rst_restart_lit", 32'(inst_pc), 32'(RESET_PC));

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 3000; n++) begin
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = 8'($urandom_range(0, 255));
         halt        = ($urandom_range(0, 15) == 0);
         inst_ready  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) reset_pulse();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00: the fetch address loaded on reset.
REQ-002 The block SHALL have parameter DEPTH, default 2: prefetch queue entries, legal range 2..4.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port pc_out  output  8: fetch address driven to the instruction memory.
REQ-006 Port inst_in  input  16: instruction word returned combinationally by memory for pc_out in the same cycle.
REQ-007 Port redirect  input  1: branch/jump request; priority over all other activity.
REQ-008 Port redirect_pc  input  8: target address, sampled when redirect=1.
REQ-009 Port halt  input  1: stop-fetch request from decode.
REQ-010 Port inst_valid  output  1: queue head holds a valid instruction.
REQ-011 Port inst_out  output  16: queue head instruction word.
REQ-012 Port inst_pc  output  8: address from which inst_out was fetched.
REQ-013 Port inst_ready  input  1: decode accepts the head; a pop occurs when inst_valid && inst_ready.
REQ-014 Port halted  output  1: FSM is in HALTED.

Function
REQ-015 The FSM SHALL have two states: RUN (fetching) and HALTED (no fetching).
REQ-016 In RUN, with redirect=0, a push of {pc_out, inst_in} SHALL occur when count<DEPTH or a pop occurs the same cycle; on push, pc_out SHALL advance by 1 modulo 256 (8'hFF -> 8'h00).
REQ-017 With no push, pc_out SHALL hold.
REQ-018 Fetch-to-output latency SHALL be 1 cycle: a word pushed at edge N is visible at the head after edge N when the queue was empty.
REQ-019 Queue order SHALL be FIFO; a simultaneous push and pop with a full queue SHALL keep count unchanged.
REQ-020 When redirect=1 (any state): a pop on that cycle completes; all entries are then flushed (count=0); pc_out <= redirect_pc; no push that cycle; the FSM goes to RUN.
REQ-021 When halt=1 with redirect=0 in RUN: the FSM goes to HALTED; no push that cycle; queued entries remain and may still be popped.
REQ-022 In HALTED, the FSM SHALL stay until redirect=1; halt SHALL be ignored there.
REQ-023 When inst_valid=0, inst_out and inst_pc SHALL read 16'h0000 and 8'h00.
REQ-024 inst_valid SHALL equal (count != 0), and inst_valid SHALL never be driven from inst_ready combinationally.
REQ-025 pc_out SHALL be a register output, with no combinational path from any input.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately, regardless of clk, set pc_out=RESET_PC, count=0, inst_valid=0, inst_out=0, inst_pc=0, state=RUN, halted=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; the first push after release SHALL be RESET_PC on the first rising edge with rst_n=1.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (RUN, HALTED), PC_W=8, INST_W=16, and the HALT opcode constant 4'b1000 for decode.
REQ-029 The queue SHALL be one sub-module, fetch_queue (DEPTH-entry FIFO with push, pop, flush, count), instantiated once.

Verification
REQ-030 Reset release with memory words 0..7 loaded and inst_ready=1 -> inst_pc sequence 0,1,2,... on consecutive cycles starting 1 cycle after release; inst_out matches memory.
REQ-031 inst_ready=0 for 5 cycles from reset -> pc_out stops at 8'h02, inst_valid=1, head stays pc 0; on inst_ready=1, output continues 0,1,2 with no gap.
REQ-032 redirect=1, redirect_pc=8'h40 while queue is full -> next cycle inst_valid=0 and pc_out=8'h40; next inst_pc is 8'h40, with no stale entries.
REQ-033 redirect to 8'hFE with inst_ready=1 -> inst_pc sequence FE, FF, 00, 01.
REQ-034 halt=1 at pc_out=8'h05 -> halted=1, pc_out holds 8'h05, queued pc 3,4 drain; redirect to 8'h00 -> RUN, fetching resumes at 0.
REQ-035 rst_n pulsed low between clock edges during streaming -> outputs reach reset values before the next edge, and fetching restarts at RESET_PC.
